// File: rtl/p2p_reg_pkg.sv
// Shared types and helpers for the p2p AXI-Lite to register-port bridge.
// Holds the FSM state encoding, the AXI response codes and the byte-merge helper.
package p2p_reg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_RD,
        ST_WR_WAIT,
        ST_WR,
        ST_B,
        ST_RD,
        ST_RD_WAIT,
        ST_R
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Strobed bytes come from new_v, the rest keep old_v.
    function automatic logic [31:0] strb_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  strb);
        logic [31:0] m;
        m = old_v;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) m[i*8 +: 8] = new_v[i*8 +: 8];
        end
        return m;
    endfunction

endpackage

// File: rtl/p2p_axil_reg_bridge.sv
// AXI4-Lite slave that serialises control-plane accesses onto the register file's
// system port; partial-strobe writes are done as read-modify-write.
module p2p_axil_reg_bridge
    import p2p_reg_pkg::*;
#(
    parameter int ENTRIES      = 12,
    parameter int DATA_WIDTH   = 32,
    parameter int AXIL_ADDR_W  = 12,
    parameter int READ_LATENCY = 0,
    localparam int IDX_W       = $clog2(ENTRIES)
) (
    input  logic                   axil_aclk,
    input  logic                   axil_rst,

    input  logic                   s_axil_awvalid,
    output logic                   s_axil_awready,
    input  logic [AXIL_ADDR_W-1:0] s_axil_awaddr,
    input  logic                   s_axil_wvalid,
    output logic                   s_axil_wready,
    input  logic [DATA_WIDTH-1:0]  s_axil_wdata,
    input  logic [3:0]             s_axil_wstrb,
    output logic                   s_axil_bvalid,
    input  logic                   s_axil_bready,
    output logic [1:0]             s_axil_bresp,

    input  logic                   s_axil_arvalid,
    output logic                   s_axil_arready,
    input  logic [AXIL_ADDR_W-1:0] s_axil_araddr,
    output logic                   s_axil_rvalid,
    input  logic                   s_axil_rready,
    output logic [DATA_WIDTH-1:0]  s_axil_rdata,
    output logic [1:0]             s_axil_rresp,

    output logic                   reg_en,
    output logic                   reg_we,
    output logic [IDX_W-1:0]       reg_addr,
    output logic [DATA_WIDTH-1:0]  reg_din,
    input  logic [DATA_WIDTH-1:0]  reg_dout
);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    r_rd_pri;
    logic [IDX_W-1:0]        r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [3:0]              r_strb;
    logic [DATA_WIDTH-1:0]   r_old;
    logic [1:0]              r_bresp;
    logic [1:0]              r_rresp;
    logic [DATA_WIDTH-1:0]   r_rdata;

    logic w_wr_cand;
    logic w_take_wr;
    logic w_take_rd;
    logic w_aw_ok;
    logic w_ar_ok;
    logic w_cap_old;
    logic w_cap_rd;

    assign w_wr_cand = s_axil_awvalid && s_axil_wvalid;
    assign w_aw_ok   = 32'(s_axil_awaddr >> 2) < 32'(ENTRIES);
    assign w_ar_ok   = 32'(s_axil_araddr >> 2) < 32'(ENTRIES);

    // With a registered register file the data is sampled one cycle later, in the *_WAIT state.
    assign w_cap_old = (READ_LATENCY == 0) ? (r_state == ST_WR_RD) : (r_state == ST_WR_WAIT);
    assign w_cap_rd  = (READ_LATENCY == 0) ? (r_state == ST_RD)    : (r_state == ST_RD_WAIT);

    always_comb begin
        w_state_nxt = r_state;
        w_take_wr   = 1'b0;
        w_take_rd   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // r_rd_pri set means the read side lost the last contention and goes first now.
                if (w_wr_cand && (!s_axil_arvalid || !r_rd_pri)) begin
                    w_take_wr = 1'b1;
                    if (!w_aw_ok || s_axil_wstrb == 4'h0) w_state_nxt = ST_B;
                    else if (s_axil_wstrb == 4'hF)        w_state_nxt = ST_WR;
                    else                                  w_state_nxt = ST_WR_RD;
                end else if (s_axil_arvalid) begin
                    w_take_rd   = 1'b1;
                    w_state_nxt = w_ar_ok ? ST_RD : ST_R;
                end
            end
            ST_WR_RD:   w_state_nxt = (READ_LATENCY == 0) ? ST_WR : ST_WR_WAIT;
            ST_WR_WAIT: w_state_nxt = ST_WR;
            ST_WR:      w_state_nxt = ST_B;
            ST_B:       if (s_axil_bready) w_state_nxt = ST_IDLE;
            ST_RD:      w_state_nxt = (READ_LATENCY == 0) ? ST_R : ST_RD_WAIT;
            ST_RD_WAIT: w_state_nxt = ST_R;
            ST_R:       if (s_axil_rready) w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
        if (axil_rst) begin
            w_take_wr   = 1'b0;
            w_take_rd   = 1'b0;
            w_state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge axil_aclk) begin
        if (axil_rst) begin
            r_state  <= ST_IDLE;
            r_rd_pri <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_strb   <= '0;
            r_old    <= '0;
            r_bresp  <= RESP_OKAY;
            r_rresp  <= RESP_OKAY;
            r_rdata  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_take_wr) begin
                r_addr  <= s_axil_awaddr[IDX_W+1:2];
                r_wdata <= s_axil_wdata;
                r_strb  <= s_axil_wstrb;
                r_bresp <= w_aw_ok ? RESP_OKAY : RESP_SLVERR;
                if (s_axil_arvalid) r_rd_pri <= 1'b1;
            end
            if (w_take_rd) begin
                r_addr  <= s_axil_araddr[IDX_W+1:2];
                r_rresp <= w_ar_ok ? RESP_OKAY : RESP_SLVERR;
                r_rdata <= '0;
                if (w_wr_cand) r_rd_pri <= 1'b0;
            end
            if (w_cap_old) r_old   <= reg_dout;
            if (w_cap_rd)  r_rdata <= reg_dout;
        end
    end

    assign s_axil_awready = w_take_wr;
    assign s_axil_wready  = w_take_wr;
    assign s_axil_arready = w_take_rd;
    assign s_axil_bvalid  = !axil_rst && (r_state == ST_B);
    assign s_axil_bresp   = r_bresp;
    assign s_axil_rvalid  = !axil_rst && (r_state == ST_R);
    assign s_axil_rresp   = r_rresp;
    assign s_axil_rdata   = r_rdata;

    assign reg_en   = !axil_rst &&
                      (r_state inside {ST_WR_RD, ST_WR_WAIT, ST_WR, ST_RD, ST_RD_WAIT});
    assign reg_we   = !axil_rst && (r_state == ST_WR);
    assign reg_addr = r_addr;
    assign reg_din  = reg_we ? strb_merge(r_old, r_wdata, r_strb) : '0;

endmodule

// File: tb/tb_p2p_axil_reg_bridge.sv
// Bench for p2p_axil_reg_bridge: vector table through a response scoreboard, plus
// arbitration, backpressure and mid-transaction reset sequences.
module tb_p2p_axil_reg_bridge;
    import p2p_reg_pkg::*;

    localparam int ENTRIES = 12;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        awvalid = 1'b0, awready, wvalid = 1'b0, wready;
    logic [11:0] awaddr = '0, araddr = '0;
    logic [31:0] wdata = '0, rdata;
    logic [3:0]  wstrb = '0;
    logic        bvalid, bready = 1'b1, arvalid = 1'b0, arready, rvalid, rready = 1'b1;
    logic [1:0]  bresp, rresp;
    logic        reg_en, reg_we;
    logic [3:0]  reg_addr;
    logic [31:0] reg_din, reg_dout;

    always #5 clk = ~clk;

    p2p_axil_reg_bridge #(.ENTRIES(ENTRIES), .DATA_WIDTH(32), .AXIL_ADDR_W(12), .READ_LATENCY(0)) dut (
        .axil_aclk(clk), .axil_rst(rst),
        .s_axil_awvalid(awvalid), .s_axil_awready(awready), .s_axil_awaddr(awaddr),
        .s_axil_wvalid(wvalid), .s_axil_wready(wready), .s_axil_wdata(wdata), .s_axil_wstrb(wstrb),
        .s_axil_bvalid(bvalid), .s_axil_bready(bready), .s_axil_bresp(bresp),
        .s_axil_arvalid(arvalid), .s_axil_arready(arready), .s_axil_araddr(araddr),
        .s_axil_rvalid(rvalid), .s_axil_rready(rready), .s_axil_rdata(rdata), .s_axil_rresp(rresp),
        .reg_en(reg_en), .reg_we(reg_we), .reg_addr(reg_addr), .reg_din(reg_din), .reg_dout(reg_dout)
    );

    // Register file stand-in: combinational read, write on the clock edge.
    logic [31:0] mem [16] = '{default: 32'h0};
    assign reg_dout = mem[reg_addr];
    always @(posedge clk) if (reg_en && reg_we) mem[reg_addr] <= reg_din;

    int n_wr = 0, n_rd = 0, n_bad = 0, n_bv = 0;
    always @(negedge clk) begin
        if (reg_en && reg_we)  n_wr  <= n_wr + 1;
        if (reg_en && !reg_we) n_rd  <= n_rd + 1;
        if (reg_we && !reg_en) n_bad <= n_bad + 1;
        if (bvalid)            n_bv  <= n_bv + 1;
    end

    typedef struct {
        logic        wr;
        logic [11:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
    } vec_t;

    typedef struct {
        logic        wr;
        logic [1:0]  resp;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   ntests = 0, nfail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0:       return awready;
            1:       return arready;
            2:       return bvalid;
            default: return rvalid;
        endcase
    endfunction

    task automatic wait_sig(input int sel, input string name);
        int k = 0;
        while (!sig(sel) && k < 30) begin
            @(negedge clk); #1;
            k++;
        end
        check(name, 32'(k < 30), 32'd1);
    endtask

    task automatic xact(input vec_t v, input string tag, output int lat);
        exp_t e;
        e.wr = v.wr; e.resp = v.exp_resp; e.data = v.exp_data;
        sb.push_back(e);
        @(negedge clk);
        if (v.wr) begin
            awvalid = 1'b1; wvalid = 1'b1; awaddr = v.addr; wdata = v.data; wstrb = v.strb;
        end else begin
            arvalid = 1'b1; araddr = v.addr;
        end
        #1;
        wait_sig(v.wr ? 0 : 1, {tag, "_accept"});
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!(v.wr ? bvalid : rvalid) && lat < 30);
        #1;
        e = sb.pop_front();
        if (e.wr) check({tag, "_bresp"}, 32'(bresp), 32'(e.resp));
        else begin
            check({tag, "_rresp"}, 32'(rresp), 32'(e.resp));
            check({tag, "_rdata"}, rdata, e.data);
        end
        @(posedge clk); #1;
    endtask

    function automatic logic outs_any();
        return |{awready, wready, arready, bvalid, rvalid, reg_en, reg_we,
                 bresp, rresp, rdata, reg_addr, reg_din};
    endfunction

    localparam int NV = 19;
    vec_t vt [NV];

    initial begin
        int lat, w0, r0, ewr, erd, elat, bad, bv0;
        logic oor;

        vt[0]  = '{1'b1, 12'h008, 32'hDEADBEEF, 4'hF, 32'h0,        RESP_OKAY};
        vt[1]  = '{1'b0, 12'h008, 32'h0,        4'h0, 32'hDEADBEEF, RESP_OKAY};
        vt[2]  = '{1'b1, 12'h008, 32'h00001234, 4'h3, 32'h0,        RESP_OKAY};
        vt[3]  = '{1'b0, 12'h008, 32'h0,        4'h0, 32'hDEAD1234, RESP_OKAY};
        vt[4]  = '{1'b1, 12'h030, 32'h11111111, 4'hF, 32'h0,        RESP_SLVERR};
        vt[5]  = '{1'b0, 12'hFFC, 32'h0,        4'h0, 32'h0,        RESP_SLVERR};
        vt[6]  = '{1'b0, 12'h02C, 32'h0,        4'h0, 32'h0,        RESP_OKAY};
        vt[7]  = '{1'b1, 12'h02C, 32'hA5A5A5A5, 4'hF, 32'h0,        RESP_OKAY};
        vt[8]  = '{1'b1, 12'h02E, 32'h00770000, 4'h4, 32'h0,        RESP_OKAY};
        vt[9]  = '{1'b0, 12'h02F, 32'h0,        4'h0, 32'hA577A5A5, RESP_OKAY};
        vt[10] = '{1'b1, 12'h02C, 32'h12345678, 4'h0, 32'h0,        RESP_OKAY};
        vt[11] = '{1'b0, 12'h02C, 32'h0,        4'h0, 32'hA577A5A5, RESP_OKAY};
        vt[12] = '{1'b1, 12'h004, 32'hCAFEF00D, 4'h9, 32'h0,        RESP_OKAY};
        vt[13] = '{1'b0, 12'h004, 32'h0,        4'h0, 32'hCA00000D, RESP_OKAY};
        vt[14] = '{1'b0, 12'h030, 32'h0,        4'h0, 32'h0,        RESP_SLVERR};
        vt[15] = '{1'b1, 12'h000, 32'h01020304, 4'hF, 32'h0,        RESP_OKAY};
        vt[16] = '{1'b0, 12'h001, 32'h0,        4'h0, 32'h01020304, RESP_OKAY};
        vt[17] = '{1'b0, 12'h00C, 32'h0,        4'h0, 32'h0BADCAFE, RESP_OKAY};
        vt[18] = '{1'b1, 12'hFFC, 32'h0,        4'h3, 32'h0,        RESP_SLVERR};

        // Reset: everything quiet, readies held low even with requests pending.
        repeat (2) @(posedge clk);
        #1;
        check("rst_outputs_zero", 32'(outs_any()), 32'd0);
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        #1;
        check("rst_readies_gated", 32'({awready, wready, arready}), 32'd0);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        // Contention straight out of reset: write wins, then read sees the new data.
        @(negedge clk);
        awvalid = 1'b1; wvalid = 1'b1; awaddr = 12'h00C; wdata = 32'h13572468; wstrb = 4'hF;
        arvalid = 1'b1; araddr = 12'h00C;
        #1;
        check("arb1_awready", 32'(awready && wready), 32'd1);
        check("arb1_arready", 32'(arready), 32'd0);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        wait_sig(1, "arb1_rd_accept");
        @(posedge clk); #1;
        arvalid = 1'b0;
        wait_sig(3, "arb1_rvalid");
        check("arb1_rdata", rdata, 32'h13572468);
        @(posedge clk); #1;

        // Second contention: read goes first and still sees the old data.
        @(negedge clk);
        awvalid = 1'b1; wvalid = 1'b1; awaddr = 12'h00C; wdata = 32'h0BADCAFE; wstrb = 4'hF;
        arvalid = 1'b1; araddr = 12'h00C;
        #1;
        check("arb2_arready", 32'(arready), 32'd1);
        check("arb2_awready", 32'(awready), 32'd0);
        @(posedge clk); #1;
        arvalid = 1'b0;
        wait_sig(3, "arb2_rvalid");
        check("arb2_rdata", rdata, 32'h13572468);
        @(posedge clk); #1;
        wait_sig(0, "arb2_wr_accept");
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        wait_sig(2, "arb2_bvalid");
        @(posedge clk); #1;

        // Vector table through the scoreboard, with latency and strobe-count checks.
        for (int i = 0; i < NV; i++) begin
            oor = 32'(vt[i].addr >> 2) >= ENTRIES;
            if (vt[i].wr) begin
                ewr  = (!oor && vt[i].strb != 4'h0) ? 1 : 0;
                erd  = (!oor && vt[i].strb != 4'h0 && vt[i].strb != 4'hF) ? 1 : 0;
                elat = (oor || vt[i].strb == 4'h0) ? 1 : ((vt[i].strb == 4'hF) ? 2 : 3);
            end else begin
                ewr  = 0;
                erd  = oor ? 0 : 1;
                elat = oor ? 1 : 2;
            end
            w0 = n_wr; r0 = n_rd;
            xact(vt[i], $sformatf("vec%0d", i), lat);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(elat));
            check($sformatf("vec%0d_wr_strobes", i), 32'(n_wr - w0), 32'(ewr));
            check($sformatf("vec%0d_rd_strobes", i), 32'(n_rd - r0), 32'(erd));
        end

        // Write response backpressure with a second write waiting behind it.
        bready = 1'b0;
        @(negedge clk);
        awvalid = 1'b1; wvalid = 1'b1; awaddr = 12'h014; wdata = 32'h55AA55AA; wstrb = 4'hF;
        #1;
        wait_sig(0, "bp_wr_accept");
        @(posedge clk); #1;
        awaddr = 12'h018; wdata = 32'h66BB66BB;
        wait_sig(2, "bp_bvalid");
        bad = 0;
        repeat (10) begin
            @(negedge clk); #1;
            if (!bvalid || bresp !== RESP_OKAY || awready) bad++;
        end
        check("bp_b_hold", 32'(bad), 32'd0);
        bready = 1'b1;
        #1;
        check("bp_aw_blocked_in_bhs", 32'(awready), 32'd0);
        @(negedge clk); #1;
        check("bp_aw_next_cycle", 32'(awready), 32'd1);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        wait_sig(2, "bp_bvalid2");
        @(posedge clk); #1;

        // Read response backpressure, rdata must stay put.
        rready = 1'b0;
        @(negedge clk);
        arvalid = 1'b1; araddr = 12'h014;
        #1;
        wait_sig(1, "bpr_rd_accept");
        @(posedge clk); #1;
        araddr = 12'h018;
        wait_sig(3, "bpr_rvalid");
        bad = 0;
        repeat (10) begin
            @(negedge clk); #1;
            if (!rvalid || rdata !== 32'h55AA55AA || rresp !== RESP_OKAY || arready) bad++;
        end
        check("bpr_r_hold", 32'(bad), 32'd0);
        rready = 1'b1;
        #1;
        check("bpr_ar_blocked_in_rhs", 32'(arready), 32'd0);
        @(negedge clk); #1;
        check("bpr_ar_next_cycle", 32'(arready), 32'd1);
        @(posedge clk); #1;
        arvalid = 1'b0;
        wait_sig(3, "bpr_rvalid2");
        check("bpr_rdata2", rdata, 32'h66BB66BB);
        @(posedge clk); #1;

        // Reset while the partial write is in its read phase.
        w0 = n_wr;
        @(negedge clk);
        awvalid = 1'b1; wvalid = 1'b1; awaddr = 12'h008; wdata = 32'h000000FF; wstrb = 4'h1;
        #1;
        wait_sig(0, "rstx_accept");
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        @(negedge clk); #1;
        check("rstx_in_wr_rd", 32'({reg_en, reg_we}), 32'h2);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rstx_outputs_zero", 32'(outs_any()), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        bv0 = n_bv;
        repeat (5) @(posedge clk);
        #1;
        check("rstx_no_wr_strobe", 32'(n_wr - w0), 32'd0);
        check("rstx_no_bvalid", 32'(n_bv - bv0), 32'd0);
        xact('{1'b0, 12'h008, 32'h0, 4'h0, 32'hDEAD1234, RESP_OKAY}, "rstx_readback", lat);

        check("we_without_en", 32'(n_bad), 32'd0);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, limit 500000 ns");
        $fatal(1, "watchdog");
    end

endmodule
